// File: rtl/snow64_scalar_store_sequencer_pkg.sv
// Shared types for the scalar store sequencer.
// Line/scalar/offset types match the scalar data shifter.
package snow64_scalar_store_sequencer_pkg;

  localparam int LineW   = 256;
  localparam int ScalarW = 64;
  localparam int OffsetW = 5;
  localparam int SizeW   = 2;

  typedef logic [LineW-1:0]   LarData;
  typedef logic [ScalarW-1:0] ScalarData;
  typedef logic [OffsetW-1:0] DataOffset;
  typedef logic [SizeW-1:0]   IntTypeSize;

  typedef enum logic [2:0] {
    StIdle,
    StRd,
    StRdWait,
    StMerge,
    StWr
  } StoreSeqState;

  typedef struct packed {
    ScalarData  scalar;
    IntTypeSize int_type_size;
    DataOffset  data_offset;
  } PortIn_ScalarStoreReq;

  // Low offset bits that must be zero for a
  // naturally aligned access of this size.
  function automatic DataOffset size_byte_mask(
    input IntTypeSize sz
  );
    DataOffset m;
    m = '0;
    unique case (1'b1)
      (sz == 2'd0): m = 5'd0;
      (sz == 2'd1): m = 5'd1;
      (sz == 2'd2): m = 5'd3;
      default:      m = 5'd7;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/snow64_scalar_store_sequencer_if.sv
// Store request channel (valid/ready) into the
// scalar store sequencer.
interface snow64_scalar_store_sequencer_if
  import snow64_scalar_store_sequencer_pkg::*;
#(
  parameter int LAR_IDX_W = 4
);

  logic                 in_req_valid;
  logic                 out_req_ready;
  logic [LAR_IDX_W-1:0] in_req_lar_idx;
  ScalarData            in_req_scalar;
  IntTypeSize           in_req_int_type_size;
  DataOffset            in_req_data_offset;

  modport master (
    output in_req_valid,
    output in_req_lar_idx,
    output in_req_scalar,
    output in_req_int_type_size,
    output in_req_data_offset,
    input  out_req_ready
  );

  modport slave (
    input  in_req_valid,
    input  in_req_lar_idx,
    input  in_req_scalar,
    input  in_req_int_type_size,
    input  in_req_data_offset,
    output out_req_ready
  );

endinterface

// File: rtl/snow64_scalar_store_sequencer_align.sv
// Store alignment: size to byte mask, offset
// forced down to natural alignment.
module snow64_scalar_store_align
  import snow64_scalar_store_sequencer_pkg::*;
(
  input  IntTypeSize i_size,
  input  DataOffset  i_offset,
  output DataOffset  o_byte_mask,
  output DataOffset  o_aligned,
  output logic       o_misaligned
);

  DataOffset w_mask;

  assign w_mask       = size_byte_mask(i_size);
  assign o_byte_mask  = w_mask;
  assign o_aligned    = i_offset & ~w_mask;
  assign o_misaligned = |(i_offset & w_mask);

endmodule

// File: rtl/snow64_scalar_store_sequencer.sv
// Scalar store sequencer: read LAR line, drive shifter, write back.
// Define SNOW64_STORE_SEQ_FORWARD_EN to forward the last written line.
module snow64_scalar_store_sequencer
  import snow64_scalar_store_sequencer_pkg::*;
#(
  parameter int LAR_IDX_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  snow64_scalar_store_sequencer_if.slave req,
  output logic                 out_lar_rd_req,
  output logic [LAR_IDX_W-1:0] out_lar_rd_idx,
  input  logic                 in_lar_rd_valid,
  input  LarData               in_lar_rd_data,
  output LarData               out_shf_to_modify,
  output ScalarData            out_shf_to_shift,
  output IntTypeSize           out_shf_int_type_size,
  output DataOffset            out_shf_data_offset,
  input  LarData               in_shf_data,
  output logic                 out_lar_wr_valid,
  input  logic                 in_lar_wr_ready,
  output logic [LAR_IDX_W-1:0] out_lar_wr_idx,
  output LarData               out_lar_wr_data,
  input  logic                 in_lar_invalidate,
  output logic                 out_done,
  output logic                 out_misaligned
);

  StoreSeqState         r_state;
  StoreSeqState         w_state_next;
  PortIn_ScalarStoreReq r_req;
  logic [LAR_IDX_W-1:0] r_idx;
  LarData               r_line;
  LarData               r_wr_data;
  logic                 r_live;

  logic      w_accept;
  logic      w_fwd_hit;
  logic      w_misaligned;
  logic      w_wr_hs;
  DataOffset w_aligned;
  DataOffset w_unused_mask;

  snow64_scalar_store_align u_align (
    .i_size       (req.in_req_int_type_size),
    .i_offset     (req.in_req_data_offset),
    .o_byte_mask  (w_unused_mask),
    .o_aligned    (w_aligned),
    .o_misaligned (w_misaligned)
  );

  assign req.out_req_ready =
    r_live & (r_state == StIdle);

  assign w_accept =
    req.in_req_valid & req.out_req_ready;

  assign w_wr_hs =
    (r_state == StWr) & in_lar_wr_ready;

`ifdef SNOW64_STORE_SEQ_FORWARD_EN
  logic r_fwd_valid;

  // Holder: r_wr_data still mirrors LAR r_idx
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fwd_valid <= 1'b0;
    end else if (in_lar_invalidate) begin
      r_fwd_valid <= 1'b0;
    end else if (w_wr_hs) begin
      r_fwd_valid <= 1'b1;
    end
  end

  assign w_fwd_hit = r_fwd_valid
    & ~in_lar_invalidate
    & (req.in_req_lar_idx == r_idx);
`else
  logic w_unused_inval;
  assign w_unused_inval = in_lar_invalidate;
  assign w_fwd_hit      = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (w_accept) begin
          w_state_next = w_fwd_hit ? StMerge : StRd;
        end
      end
      StRd: begin
        w_state_next = StRdWait;
      end
      StRdWait: begin
        if (in_lar_rd_valid) begin
          w_state_next = StMerge;
        end
      end
      StMerge: begin
        w_state_next = StWr;
      end
      StWr: begin
        if (in_lar_wr_ready) begin
          w_state_next = StIdle;
        end
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  // Request latch, line capture, merge capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_live    <= 1'b0;
      r_idx     <= '0;
      r_req     <= '0;
      r_line    <= '0;
      r_wr_data <= '0;
    end else begin
      r_live <= 1'b1;
      if (w_accept) begin
        r_idx               <= req.in_req_lar_idx;
        r_req.scalar        <= req.in_req_scalar;
        r_req.int_type_size <= req.in_req_int_type_size;
        r_req.data_offset   <= w_aligned;
        if (w_fwd_hit) begin
          r_line <= r_wr_data;
        end
      end
      if ((r_state == StRdWait) && in_lar_rd_valid) begin
        r_line <= in_lar_rd_data;
      end
      if (r_state == StMerge) begin
        r_wr_data <= in_shf_data;
      end
    end
  end

  assign out_lar_rd_req        = (r_state == StRd);
  assign out_lar_rd_idx        = r_idx;
  assign out_shf_to_modify     = r_line;
  assign out_shf_to_shift      = r_req.scalar;
  assign out_shf_int_type_size = r_req.int_type_size;
  assign out_shf_data_offset   = r_req.data_offset;
  assign out_lar_wr_valid      = (r_state == StWr);
  assign out_lar_wr_idx        = r_idx;
  assign out_lar_wr_data       = r_wr_data;
  assign out_done              = w_wr_hs;
  assign out_misaligned        = w_accept & w_misaligned;

endmodule

// File: tb/tb_snow64_scalar_store_sequencer.sv
// Bench for the scalar store sequencer with a
// behavioural shifter and LAR file around it.
module tb_snow64_scalar_store_sequencer;
  import snow64_scalar_store_sequencer_pkg::*;

`ifdef SNOW64_STORE_SEQ_FORWARD_EN
  localparam bit FwdEn = 1'b1;
`else
  localparam bit FwdEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  snow64_scalar_store_sequencer_if #(.LAR_IDX_W(4)) req_if ();

  logic       rd_req;
  logic [3:0] rd_idx;
  logic       rd_valid;
  LarData     rd_data;
  LarData     shf_mod;
  ScalarData  shf_sc;
  IntTypeSize shf_sz;
  DataOffset  shf_off;
  LarData     shf_data;
  logic       wr_valid;
  logic       wr_ready;
  logic [3:0] wr_idx;
  LarData     wr_data;
  logic       inval;
  logic       done;
  logic       mis;

  snow64_scalar_store_sequencer #(.LAR_IDX_W(4)) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .req                   (req_if),
    .out_lar_rd_req        (rd_req),
    .out_lar_rd_idx        (rd_idx),
    .in_lar_rd_valid       (rd_valid),
    .in_lar_rd_data        (rd_data),
    .out_shf_to_modify     (shf_mod),
    .out_shf_to_shift      (shf_sc),
    .out_shf_int_type_size (shf_sz),
    .out_shf_data_offset   (shf_off),
    .in_shf_data           (shf_data),
    .out_lar_wr_valid      (wr_valid),
    .in_lar_wr_ready       (wr_ready),
    .out_lar_wr_idx        (wr_idx),
    .out_lar_wr_data       (wr_data),
    .in_lar_invalidate     (inval),
    .out_done              (done),
    .out_misaligned        (mis)
  );

  // Shifter model: masked insert at the given offset
  function automatic LarData shifter(
    LarData l, ScalarData s, IntTypeSize z, DataOffset o);
    LarData m;
    LarData v;
    int bits;
    bits = 8 << z;
    m = ((LarData'(1) << bits) - 1) << (int'(o) * 8);
    v = LarData'(s) << (int'(o) * 8);
    return (l & ~m) | (v & m);
  endfunction

  assign shf_data = shifter(shf_mod, shf_sc, shf_sz, shf_off);

  // Reference: byte-array store at the aligned offset
  function automatic LarData ref_store(
    LarData l, ScalarData s, int sz, int off);
    logic [7:0] b [32];
    LarData r;
    int n;
    int base;
    n = 1 << sz;
    base = off - (off % n);
    for (int i = 0; i < 32; i++) b[i] = l[i*8 +: 8];
    for (int i = 0; i < n; i++) b[base+i] = s[i*8 +: 8];
    for (int i = 0; i < 32; i++) r[i*8 +: 8] = b[i];
    return r;
  endfunction

  function automatic LarData rand_line();
    LarData l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  LarData lar_mem [16];
  LarData ref_mem [16];
  int checks = 0;
  int failures = 0;

  task automatic check(input string name,
    input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic check_int(input string name,
    input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  // One store; cycle 0 is the accept cycle
  task automatic run_store(
    input logic [3:0] idx, input ScalarData sc,
    input IntTypeSize sz, input DataOffset off,
    input int rd_dly, input int stall,
    input logic acc_inval,
    output LarData wdata, output logic [3:0] widx,
    output logic got_mis, output logic got_rdy,
    output int done_cyc, output int nrd,
    output logic proto);
    int rd_at;
    int nwr;
    logic hs;
    LarData fdata;
    logic [3:0] fidx;
    logic [3:0] rdi;
    rd_at = -1; nwr = 0; nrd = 0; done_cyc = -1;
    proto = 1'b1; hs = 1'b0; got_mis = 1'b0;
    wdata = '0; widx = '0; fdata = '0;
    fidx = '0; rdi = '0;
    got_rdy = req_if.out_req_ready;
    req_if.in_req_valid = 1'b1;
    req_if.in_req_lar_idx = idx;
    req_if.in_req_scalar = sc;
    req_if.in_req_int_type_size = sz;
    req_if.in_req_data_offset = off;
    for (int cyc = 0; cyc < 40 && !hs; cyc++) begin
      if (cyc > 0) begin
        req_if.in_req_lar_idx = 4'($urandom);
        req_if.in_req_scalar = {$urandom, $urandom};
        req_if.in_req_int_type_size = 2'($urandom);
        req_if.in_req_data_offset = 5'($urandom);
        inval = 1'b0;
      end else begin
        inval = acc_inval;
      end
      rd_valid = (cyc == 0) ||
        (rd_at >= 0 && cyc == rd_at + rd_dly);
      rd_data = (rd_valid && cyc > 0) ?
        lar_mem[rdi] : rand_line();
      if (rd_req) begin
        nrd++;
        rd_at = cyc;
        rdi = rd_idx;
      end
      if (wr_valid) begin
        nwr++;
        if (nwr == 1) begin
          fdata = wr_data;
          fidx = wr_idx;
        end else if (wr_data !== fdata || wr_idx !== fidx) begin
          proto = 1'b0;
        end
        if (req_if.out_req_ready !== 1'b0) proto = 1'b0;
        wr_ready = (nwr > stall);
      end else begin
        wr_ready = 1'($urandom_range(0, 1));
      end
      #1;
      if (cyc == 0) got_mis = mis;
      else if (mis) proto = 1'b0;
      if (wr_valid && wr_ready) begin
        hs = 1'b1;
        wdata = wr_data;
        widx = wr_idx;
        done_cyc = done ? cyc : -2;
        lar_mem[wr_idx] = wr_data;
      end else if (done) begin
        proto = 1'b0;
      end
      @(posedge clk);
      #1;
    end
    req_if.in_req_valid = 1'b0;
    wr_ready = 1'b0;
    rd_valid = 1'b0;
    inval = 1'b0;
  endtask

  typedef struct {
    logic [3:0] idx;
    ScalarData  sc;
    IntTypeSize sz;
    DataOffset  off;
    LarData     init;
    LarData     exp;
    logic       exp_mis;
  } vec_t;

  vec_t vt [6];

  LarData     g_data;
  LarData     e1;
  LarData     e2;
  logic [3:0] g_idx;
  logic       g_mis;
  logic       g_rdy;
  logic       g_proto;
  int         g_done;
  int         g_nrd;
  int         bad;
  logic       hv;
  logic [3:0] hi;

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    vt[0] = '{idx: 4'd0, sc: 64'h1122334455667788,
      sz: 2'd3, off: 5'd8, init: {32{8'hAA}},
      exp: {{16{8'hAA}}, 64'h1122334455667788, {8{8'hAA}}},
      exp_mis: 1'b0};
    vt[1] = '{idx: 4'd1, sc: 64'h000000000000005A,
      sz: 2'd0, off: 5'd31, init: '0,
      exp: {8'h5A, 248'h0}, exp_mis: 1'b0};
    vt[2] = '{idx: 4'd2, sc: 64'hCAFEF00DDEADBEEF,
      sz: 2'd2, off: 5'd6, init: {32{8'hFF}},
      exp: {{24{8'hFF}}, 32'hDEADBEEF, 32'hFFFFFFFF},
      exp_mis: 1'b1};
    vt[3] = '{idx: 4'd4, sc: 64'h123456789ABCABCD,
      sz: 2'd1, off: 5'd31, init: '0,
      exp: {16'hABCD, 240'h0}, exp_mis: 1'b1};
    vt[4] = '{idx: 4'd5, sc: 64'h0102030405060708,
      sz: 2'd3, off: 5'd25, init: {32{8'h55}},
      exp: {64'h0102030405060708, {24{8'h55}}},
      exp_mis: 1'b1};
    vt[5] = '{idx: 4'd6, sc: 64'hFFFFFFFFFFFFFF3C,
      sz: 2'd0, off: 5'd0, init: '0,
      exp: {248'h0, 8'h3C}, exp_mis: 1'b0};

    for (int i = 0; i < 16; i++) lar_mem[i] = rand_line();
    req_if.in_req_valid = 1'b0;
    req_if.in_req_lar_idx = '0;
    req_if.in_req_scalar = '0;
    req_if.in_req_int_type_size = '0;
    req_if.in_req_data_offset = '0;
    rd_valid = 1'b0;
    rd_data = '0;
    wr_ready = 1'b0;
    inval = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", req_if.out_req_ready, 0);
    check("rst_rd_req", rd_req, 0);
    check("rst_wr_valid", wr_valid, 0);
    check("rst_wr_data", wr_data, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rel_ready", req_if.out_req_ready, 1);

    for (int i = 0; i < 6; i++) begin
      lar_mem[vt[i].idx] = vt[i].init;
      run_store(vt[i].idx, vt[i].sc, vt[i].sz,
        vt[i].off, 1, 0, 1'b0, g_data, g_idx,
        g_mis, g_rdy, g_done, g_nrd, g_proto);
      check($sformatf("v%0d_data", i), g_data, vt[i].exp);
      check($sformatf("v%0d_idx", i), g_idx, vt[i].idx);
      check($sformatf("v%0d_mis", i), g_mis, vt[i].exp_mis);
      check($sformatf("v%0d_rdy", i), g_rdy, 1);
      check_int($sformatf("v%0d_done_cyc", i), g_done, 4);
      check_int($sformatf("v%0d_nrd", i), g_nrd, 1);
      check($sformatf("v%0d_proto", i), g_proto, 1);
    end

    e1 = ref_store(lar_mem[7], 64'h00000000BEEF1234, 1, 10);
    run_store(4'd7, 64'h00000000BEEF1234, 2'd1, 5'd10,
      1, 3, 1'b0, g_data, g_idx, g_mis, g_rdy,
      g_done, g_nrd, g_proto);
    check("stall_data", g_data, e1);
    check("stall_stable", g_proto, 1);
    check_int("stall_done_cyc", g_done, 7);

    lar_mem[3] = rand_line();
    e1 = ref_store(lar_mem[3], 64'hA1A2A3A4A5A6A7A8, 3, 0);
    run_store(4'd3, 64'hA1A2A3A4A5A6A7A8, 2'd3, 5'd0,
      1, 0, 1'b0, g_data, g_idx, g_mis, g_rdy,
      g_done, g_nrd, g_proto);
    check("fwdA_data", g_data, e1);
    check_int("fwdA_nrd", g_nrd, 1);
    e2 = ref_store(e1, 64'h00000000C0C1C2C3, 2, 20);
    run_store(4'd3, 64'h00000000C0C1C2C3, 2'd2, 5'd20,
      1, 0, 1'b0, g_data, g_idx, g_mis, g_rdy,
      g_done, g_nrd, g_proto);
    check("fwdB_data", g_data, e2);
    check_int("fwdB_nrd", g_nrd, FwdEn ? 0 : 1);
    check_int("fwdB_done_cyc", g_done, FwdEn ? 2 : 4);
    lar_mem[3] = rand_line();
    inval = 1'b1;
    @(posedge clk);
    #1;
    inval = 1'b0;
    e1 = ref_store(lar_mem[3], 64'h00000000000000E7, 0, 13);
    run_store(4'd3, 64'h00000000000000E7, 2'd0, 5'd13,
      1, 0, 1'b0, g_data, g_idx, g_mis, g_rdy,
      g_done, g_nrd, g_proto);
    check("fwdC_data", g_data, e1);
    check_int("fwdC_nrd", g_nrd, 1);
    lar_mem[3] = rand_line();
    e2 = ref_store(lar_mem[3], 64'h0000000000004D4E, 1, 2);
    run_store(4'd3, 64'h0000000000004D4E, 2'd1, 5'd2,
      2, 0, 1'b1, g_data, g_idx, g_mis, g_rdy,
      g_done, g_nrd, g_proto);
    check("fwdD_data", g_data, e2);
    check_int("fwdD_nrd", g_nrd, 1);

    req_if.in_req_valid = 1'b1;
    req_if.in_req_lar_idx = 4'd9;
    req_if.in_req_scalar = 64'h0F0E0D0C0B0A0908;
    req_if.in_req_int_type_size = 2'd3;
    req_if.in_req_data_offset = 5'd0;
    @(posedge clk);
    #1;
    req_if.in_req_valid = 1'b0;
    check("rs_rd_req", rd_req, 1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("rs_ready", req_if.out_req_ready, 0);
    check("rs_rd_req0", rd_req, 0);
    check("rs_wr_valid", wr_valid, 0);
    check("rs_wr_data", wr_data, 0);
    check("rs_shf_mod", shf_mod, 0);
    check("rs_shf_sc", shf_sc, 0);
    check("rs_done", done, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    rd_valid = 1'b1;
    rd_data = rand_line();
    bad = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1;
      rd_valid = 1'b0;
      if (wr_valid || rd_req || done) bad++;
    end
    check_int("rs_no_activity", bad, 0);
    check("rs_ready_after", req_if.out_req_ready, 1);

    for (int i = 0; i < 16; i++) ref_mem[i] = lar_mem[i];
    hv = 1'b0;
    hi = '0;
    for (int n = 0; n < 60; n++) begin
      logic [3:0] ri;
      ScalarData  rs;
      IntTypeSize rz;
      DataOffset  ro;
      int         rdl;
      int         stl;
      int         k;
      logic       ai;
      logic       hit;
      LarData     ex;
      ri = 4'($urandom_range(0, 3));
      rs = {$urandom, $urandom};
      rz = 2'($urandom);
      ro = 5'($urandom);
      rdl = $urandom_range(1, 3);
      stl = $urandom_range(0, 2);
      ai = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 7) == 0) begin
        k = $urandom_range(0, 3);
        lar_mem[k] = rand_line();
        ref_mem[k] = lar_mem[k];
        inval = 1'b1;
        @(posedge clk);
        #1;
        inval = 1'b0;
        hv = 1'b0;
      end
      if (ai) ref_mem[ri] = lar_mem[ri];
      hit = FwdEn && hv && (hi == ri) && !ai;
      ex = ref_store(ref_mem[ri], rs, int'(rz), int'(ro));
      ref_mem[ri] = ex;
      run_store(ri, rs, rz, ro, rdl, stl, ai, g_data,
        g_idx, g_mis, g_rdy, g_done, g_nrd, g_proto);
      hv = 1'b1;
      hi = ri;
      check($sformatf("r%0d_data", n), g_data, ex);
      check($sformatf("r%0d_idx", n), g_idx, ri);
      check($sformatf("r%0d_mis", n), g_mis,
        (int'(ro) % (1 << rz)) != 0);
      check_int($sformatf("r%0d_nrd", n), g_nrd, hit ? 0 : 1);
      check_int($sformatf("r%0d_done_cyc", n), g_done,
        hit ? 2 + stl : 3 + rdl + stl);
      check($sformatf("r%0d_proto", n), g_proto, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d",
      checks, failures);
    $finish;
  end

endmodule
